// File: rtl/switch_event_capture_if.sv
// Event stream between the switch capture block and its consumer.
// The master side presents the FIFO head; the slave side answers with evt_ready.
interface switch_event_capture_if #(
    parameter int WIDTH = 8
);
    logic             evt_valid;
    logic             evt_ready;
    logic [WIDTH-1:0] evt_data;
    logic [WIDTH-1:0] evt_mask;

    modport master (
        output evt_valid,
        output evt_data,
        output evt_mask,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_data,
        input  evt_mask,
        output evt_ready
    );
endinterface

// File: rtl/switch_event_capture.sv
// Synchronises and debounces the switch bank, turns each debounced change into
// a {state, changed-mask} event and queues it in a small fall-through FIFO.
module switch_event_capture #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk_100MHz,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              switch_i,
    output logic [WIDTH-1:0]              sw_state,
    switch_event_capture_if.master        evt,
    output logic                          irq,
    output logic                          overflow,
    input  logic                          ovf_clr
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [WIDTH-1:0] db_q, db_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] data_q [FIFO_DEPTH];
    logic [WIDTH-1:0] data_d [FIFO_DEPTH];
    logic [WIDTH-1:0] mask_q [FIFO_DEPTH];
    logic [WIDTH-1:0] mask_d [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;

    logic push, pop, push_ok, drop, empty, full;

    // A bit flips only after CNT_LAST+1 consecutive mismatching samples.
    always_comb begin
        s1_d = switch_i;
        s2_d = s1_q;
        db_d = db_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                db_d[i]  = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Full FIFO still accepts a push when the head is popped on the same edge.
    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push       = (db_d != db_q);
        pop        = !empty && evt.evt_ready;
        push_ok    = push && (!full || pop);
        drop       = push && full && !pop;
        data_d     = data_q;
        mask_d     = mask_q;
        if (push_ok) begin
            data_d[wr_ptr_q[AW-1:0]] = db_d;
            mask_d[wr_ptr_q[AW-1:0]] = db_d ^ db_q;
        end
        wr_ptr_d   = wr_ptr_q + PW'(push_ok);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            db_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                data_q[j] <= '0;
                mask_q[j] <= '0;
            end
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            db_q       <= db_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
        end
    end

    assign sw_state      = db_q;
    assign evt.evt_valid = !empty;
    assign evt.evt_data  = data_q[rd_ptr_q[AW-1:0]];
    assign evt.evt_mask  = mask_q[rd_ptr_q[AW-1:0]];
    assign irq           = !empty;
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_switch_event_capture.sv
// Directed bench for switch_event_capture with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4:
// a vector table for reset/single-change/bounce plus hand sequences for the FIFO.
module tb_switch_event_capture;
   logic       clk_100MHz = 1'b0;
   logic       reset;
   logic [7:0] switch_i;
   logic [7:0] sw_state;
   logic       irq;
   logic       overflow;
   logic       ovf_clr;
   int         checks   = 0;
   int         failures = 0;

   switch_event_capture_if #(.WIDTH(8)) evt_if ();

   switch_event_capture #(
      .WIDTH(8),
      .DEBOUNCE_CYCLES(4),
      .FIFO_DEPTH(4)
   ) dut (
      .clk_100MHz(clk_100MHz),
      .reset(reset),
      .switch_i(switch_i),
      .sw_state(sw_state),
      .evt(evt_if.master),
      .irq(irq),
      .overflow(overflow),
      .ovf_clr(ovf_clr)
   );

   // 100 MHz clock
   always #5 clk_100MHz = ~clk_100MHz;

   typedef struct {
      logic       rst;
      logic [7:0] sw;
      logic       rdy;
      logic       clr;
      logic [7:0] st;
      logic       v;
      logic [7:0] d;
      logic [7:0] m;
      logic       ovf;
   } vec_t;

   vec_t vecs[$];

   // Appends one cycle of stimulus with the outputs expected just after its edge
   task automatic addRow(input logic rst, input logic [7:0] sw, input logic rdy,
                         input logic [7:0] st, input logic v,
                         input logic [7:0] d, input logic [7:0] m);
      vec_t r;
      r.rst = rst; r.sw = sw; r.rdy = rdy; r.clr = 1'b0;
      r.st = st; r.v = v; r.d = d; r.m = m; r.ovf = 1'b0;
      vecs.push_back(r);
   endtask

   // Drives inputs at the falling edge and returns 1 ns after the next rising edge
   task automatic applyStimulus(input logic rst, input logic [7:0] sw,
                                input logic rdy, input logic clr);
      @(negedge clk_100MHz);
      reset            = rst;
      switch_i         = sw;
      evt_if.evt_ready = rdy;
      ovf_clr          = clr;
      @(posedge clk_100MHz);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic checkHead(input string name, input logic [7:0] d, input logic [7:0] m);
      checkOutput({name, " valid"}, 32'(evt_if.evt_valid), 32'd1);
      checkOutput({name, " data"}, 32'(evt_if.evt_data), 32'(d));
      checkOutput({name, " mask"}, 32'(evt_if.evt_mask), 32'(m));
   endtask

   task automatic holdSwitch(input logic [7:0] sw, input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, sw, 1'b0, 1'b0);
   endtask

   initial begin
      reset            = 1'b1;
      switch_i         = 8'h00;
      evt_if.evt_ready = 1'b0;
      ovf_clr          = 1'b0;

      // Reset then single change 0x05; event after edge 5, popped at edge 6
      addRow(1, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);
      for (int r = 0; r < 5; r++) addRow(0, 8'h05, 0, 8'h00, 0, 8'h00, 8'h00);
      addRow(0, 8'h05, 0, 8'h05, 1, 8'h05, 8'h05);
      addRow(0, 8'h05, 1, 8'h05, 0, 8'h00, 8'h00);
      addRow(0, 8'h05, 0, 8'h05, 0, 8'h00, 8'h00);

      // Bounce: runs of 3 high cycles are rejected, the long run accepted at edge 14
      addRow(1, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00);
      for (int r = 0; r < 14; r++) begin
         logic [7:0] sw;
         sw = (r <= 2 || (r >= 4 && r <= 6) || r >= 9) ? 8'h01 : 8'h00;
         addRow(0, sw, 0, 8'h00, 0, 8'h00, 8'h00);
      end
      addRow(0, 8'h01, 0, 8'h01, 1, 8'h01, 8'h01);
      addRow(0, 8'h01, 1, 8'h01, 0, 8'h00, 8'h00);
      addRow(0, 8'h01, 0, 8'h01, 0, 8'h00, 8'h00);

      foreach (vecs[i]) begin
         string tag;
         tag = $sformatf("row%0d", i);
         applyStimulus(vecs[i].rst, vecs[i].sw, vecs[i].rdy, vecs[i].clr);
         checkOutput({tag, " sw_state"}, 32'(sw_state), 32'(vecs[i].st));
         checkOutput({tag, " valid"}, 32'(evt_if.evt_valid), 32'(vecs[i].v));
         checkOutput({tag, " irq"}, 32'(irq), 32'(vecs[i].v));
         checkOutput({tag, " overflow"}, 32'(overflow), 32'(vecs[i].ovf));
         if (vecs[i].v || vecs[i].rst) begin
            checkOutput({tag, " data"}, 32'(evt_if.evt_data), 32'(vecs[i].d));
            checkOutput({tag, " mask"}, 32'(evt_if.evt_mask), 32'(vecs[i].m));
         end
      end

      // Overflow: five changes with no reads, the fifth is dropped
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
      holdSwitch(8'h01, 6);
      holdSwitch(8'h03, 6);
      holdSwitch(8'h02, 6);
      holdSwitch(8'h00, 6);
      checkOutput("ovf before drop", 32'(overflow), 32'd0);
      holdSwitch(8'h04, 6);
      checkOutput("ovf set", 32'(overflow), 32'd1);
      checkOutput("ovf sw_state", 32'(sw_state), 32'h04);
      checkHead("ovf head0", 8'h01, 8'h01);
      applyStimulus(1'b0, 8'h04, 1'b1, 1'b0);
      checkHead("ovf head1", 8'h03, 8'h02);
      applyStimulus(1'b0, 8'h04, 1'b1, 1'b0);
      checkHead("ovf head2", 8'h02, 8'h01);
      applyStimulus(1'b0, 8'h04, 1'b1, 1'b0);
      checkHead("ovf head3", 8'h00, 8'h02);
      applyStimulus(1'b0, 8'h04, 1'b1, 1'b0);
      checkOutput("ovf drained", 32'(evt_if.evt_valid), 32'd0);
      checkOutput("ovf sticky", 32'(overflow), 32'd1);
      applyStimulus(1'b0, 8'h04, 1'b0, 1'b1);
      checkOutput("ovf cleared", 32'(overflow), 32'd0);

      // Full FIFO with a pop on the push edge keeps the new entry
      holdSwitch(8'h06, 6);
      holdSwitch(8'h07, 6);
      holdSwitch(8'h05, 6);
      holdSwitch(8'h01, 6);
      holdSwitch(8'h03, 5);
      checkHead("full head", 8'h06, 8'h02);
      applyStimulus(1'b0, 8'h03, 1'b1, 1'b0);
      checkOutput("full ovf", 32'(overflow), 32'd0);
      checkOutput("full sw_state", 32'(sw_state), 32'h03);
      checkHead("full pop0", 8'h07, 8'h01);
      applyStimulus(1'b0, 8'h03, 1'b1, 1'b0);
      checkHead("full pop1", 8'h05, 8'h02);
      applyStimulus(1'b0, 8'h03, 1'b1, 1'b0);
      checkHead("full pop2", 8'h01, 8'h04);
      applyStimulus(1'b0, 8'h03, 1'b1, 1'b0);
      checkHead("full pop3", 8'h03, 8'h02);
      applyStimulus(1'b0, 8'h03, 1'b1, 1'b0);
      checkOutput("full drained", 32'(evt_if.evt_valid), 32'd0);

      // Reset mid-operation with two queued events and a count in progress
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
      holdSwitch(8'h01, 6);
      holdSwitch(8'h03, 6);
      holdSwitch(8'h07, 3);
      checkHead("mid queued", 8'h01, 8'h01);
      @(negedge clk_100MHz);
      reset = 1'b1;
      #1;
      checkOutput("mid async valid", 32'(evt_if.evt_valid), 32'd0);
      checkOutput("mid async irq", 32'(irq), 32'd0);
      checkOutput("mid async sw_state", 32'(sw_state), 32'd0);
      checkOutput("mid async ovf", 32'(overflow), 32'd0);
      @(posedge clk_100MHz);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 8'h07, 1'b0, 1'b0);
         checkOutput($sformatf("mid quiet%0d", k), 32'(evt_if.evt_valid), 32'd0);
      end
      applyStimulus(1'b0, 8'h07, 1'b0, 1'b0);
      checkHead("mid fresh", 8'h07, 8'h07);
      checkOutput("mid fresh ovf", 32'(overflow), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
